// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers line/frame periods from sync strobes, qualifies
// lock against repeated measurements, and emits per-pixel column/row coordinates.
module vga_timing_rx #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       pix_valid,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       locked,
  output logic       sync_err
);

  if (H_ACTIVE < 1 || H_ACTIVE > 1024 || V_ACTIVE < 1 || V_ACTIVE > 1024) begin : g_param_check
    $error("vga_timing_rx: H_ACTIVE/V_ACTIVE must lie in 1..1024");
  end

  localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
  localparam logic [9:0]  CNT_MAX    = 10'd1023;

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  state_t      state, state_d;
  logic        hs_prev, vs_prev, de_prev;
  logic        hs_fall, vs_fall, de_rise, de_fall;
  logic [9:0]  per_cnt, per_cnt_nxt;
  logic [9:0]  line_cnt, line_cnt_inc, line_cnt_nxt;
  logic [10:0] cur_period, last_period, period_now;
  logic [9:0]  h_lat;
  logic        h_bad, v_bad, sat, de_bad;
  logic        latch_tot, err_d;
  logic        v_seen;

  assign hs_fall = pix_en & hs_prev & ~h_sync;
  assign vs_fall = pix_en & vs_prev & ~v_sync;
  assign de_rise = pix_en & ~de_prev & DE;
  assign de_fall = pix_en & de_prev & ~DE;

  // Line increment is applied before the frame capture, so a coincident
  // h/v edge counts the line in the frame that just ended.
  assign per_cnt_nxt  = hs_fall ? 10'd0 : ((per_cnt == CNT_MAX) ? per_cnt : per_cnt + 10'd1);
  assign cur_period   = {1'b0, per_cnt} + 11'd1;
  assign line_cnt_inc = (hs_fall && (line_cnt != CNT_MAX)) ? line_cnt + 10'd1 : line_cnt;
  assign line_cnt_nxt = vs_fall ? 10'd0 : line_cnt_inc;
  assign period_now   = hs_fall ? cur_period : last_period;
  assign h_lat        = period_now[10] ? CNT_MAX : period_now[9:0];

  assign h_bad  = hs_fall && (cur_period != {1'b0, h_total});
  assign v_bad  = vs_fall && (line_cnt_inc != v_total);
  assign sat    = pix_en && ((per_cnt_nxt == CNT_MAX) || (line_cnt_nxt == CNT_MAX));
  assign de_bad = de_fall && (({1'b0, x_pixel} + 11'd1) != H_ACTIVE_W);

  always_comb begin
    state_d   = state;
    latch_tot = 1'b0;
    err_d     = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_fall) state_d = MEASURE;
      end
      MEASURE: begin
        if (vs_fall) begin
          latch_tot = 1'b1;
          state_d   = VERIFY;
        end
      end
      VERIFY: begin
        if (h_bad) begin
          state_d = MEASURE;
        end else if (vs_fall) begin
          if (v_bad) latch_tot = 1'b1;
          else       state_d   = LOCKED;
        end
      end
      LOCKED: begin
        if (h_bad || v_bad || sat || de_bad) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // pix_valid is a one-clk qualifier for x_pixel/y_pixel of the pixel sampled
  // on the previous clk; there is no back-pressure, consumers must take it then.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      de_prev     <= 1'b0;
      per_cnt     <= 10'd0;
      line_cnt    <= 10'd0;
      last_period <= 11'd0;
      v_seen      <= 1'b0;
      x_pixel     <= 10'd0;
      y_pixel     <= 10'd0;
      pix_valid   <= 1'b0;
      h_total     <= 10'd0;
      v_total     <= 10'd0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state     <= state_d;
      locked    <= (state_d == LOCKED);
      sync_err  <= err_d;
      pix_valid <= pix_en & DE & (state == LOCKED);
      if (latch_tot) begin
        h_total <= h_lat;
        v_total <= line_cnt_inc;
      end
      if (pix_en) begin
        hs_prev  <= h_sync;
        vs_prev  <= v_sync;
        de_prev  <= DE;
        per_cnt  <= per_cnt_nxt;
        line_cnt <= line_cnt_nxt;
        if (hs_fall) last_period <= cur_period;
        if (de_rise) begin
          x_pixel <= 10'd0;
          if (v_seen || vs_fall)      y_pixel <= 10'd0;
          else if (y_pixel != CNT_MAX) y_pixel <= y_pixel + 10'd1;
        end else if (DE && (x_pixel != CNT_MAX)) begin
          x_pixel <= x_pixel + 10'd1;
        end
        if (de_rise)      v_seen <= 1'b0;
        else if (vs_fall) v_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a scaled-down raster (16x8 active, 24x12 total)
// with a pixel strobe every other clk; pixels are scoreboarded by coordinate.
module tb_vga_timing_rx;

  localparam int H_ACT    = 16;
  localparam int V_ACT    = 8;
  localparam int H_TOT    = 24;
  localparam int HS_START = 18;
  localparam int HS_END   = 20;
  localparam int VS_START = 9;
  localparam int VS_END   = 10;

  logic       clk = 1'b0;
  logic       reset, pix_en, h_sync, v_sync, de;
  logic [9:0] x_pixel, y_pixel, h_total, v_total;
  logic       pix_valid, locked, sync_err;

  vga_timing_rx #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync), .DE(de),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .pix_valid(pix_valid), .h_total(h_total),
    .v_total(v_total), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [19:0] exp_q[$];
  bit   exp_lock;
  int   lock_cd, exp_err, err_seen, pv_seen, since_h, de_run, v_edges;
  bit   m_hprev, m_vprev, m_deprev;
  logic [19:0] first_xy, last_xy;
  logic last_err;
  logic snap_pre [0:63];
  logic snap_locked [0:63];
  logic [9:0] snap_htot [0:63];
  logic [9:0] snap_vtot [0:63];

  initial begin
    err_seen = 0;
    pv_seen  = 0;
    exp_err  = 0;
    v_edges  = 0;
  end

  // Scoreboard: pop one expected coordinate per pix_valid pulse.
  always @(negedge clk) begin
    logic [19:0] e;
    if (sync_err) err_seen++;
    if (pix_valid) begin
      if (pv_seen == 0) first_xy = {y_pixel, x_pixel};
      last_xy = {y_pixel, x_pixel};
      pv_seen++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL pixel_unexpected: got y=%0d x=%0d, want no pix_valid", y_pixel, x_pixel);
      end else begin
        e = exp_q.pop_front();
        if ({y_pixel, x_pixel} !== e)
          $display("FAIL pixel_xy: got y=%0d x=%0d, want y=%0d x=%0d", y_pixel, x_pixel, e[19:10], e[9:0]);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    exp_lock = 0;
    lock_cd  = 3;
    exp_q.delete();
    m_hprev  = 1;
    m_vprev  = 1;
    m_deprev = 0;
    since_h  = 0;
    de_run   = 0;
  endtask

  task automatic drive_sample(input bit h, input bit v, input bit d, input int x, input int y);
    bit hfall, vfall, defall;
    hfall  = m_hprev && !h;
    vfall  = m_vprev && !v;
    defall = m_deprev && !d;
    h_sync = h; v_sync = v; de = d; pix_en = 1'b1;
    if (exp_lock && d) exp_q.push_back({10'(y), 10'(x)});
    since_h++;
    if (hfall) begin
      if (exp_lock && since_h != H_TOT) begin exp_lock = 0; lock_cd = 3; exp_err++; end
      since_h = 0;
    end
    if (d) de_run = m_deprev ? de_run + 1 : 1;
    if (defall && exp_lock && de_run != H_ACT) begin exp_lock = 0; lock_cd = 3; exp_err++; end
    if (vfall) begin
      v_edges++;
      snap_pre[v_edges] = locked;
    end
    m_hprev = h; m_vprev = v; m_deprev = d;
    @(posedge clk); #1;
    last_err = sync_err;
    if (vfall) begin
      snap_locked[v_edges] = locked;
      snap_htot[v_edges]   = h_total;
      snap_vtot[v_edges]   = v_total;
      if (lock_cd > 0) begin
        lock_cd--;
        if (lock_cd == 0) exp_lock = 1;
      end
    end
    pix_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_lines(input int l0, input int l1, input int long_l, input int short_l);
    int n, act;
    for (int l = l0; l <= l1; l++) begin
      n   = (l == long_l) ? H_TOT + 1 : H_TOT;
      act = (l == short_l) ? H_ACT - 1 : H_ACT;
      for (int s = 0; s < n; s++)
        drive_sample(!(s >= HS_START && s <= HS_END), !(l >= VS_START && l <= VS_END),
                     (l < V_ACT) && (s < act), s, l);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_en = 1'b0; h_sync = 1'b1; v_sync = 1'b1; de = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (x_pixel !== 10'd0) $display("FAIL reset_x: got %0d want 0", x_pixel); else pass_cnt++;
    chk_cnt++; if (y_pixel !== 10'd0) $display("FAIL reset_y: got %0d want 0", y_pixel); else pass_cnt++;
    chk_cnt++; if (pix_valid !== 1'b0) $display("FAIL reset_pix_valid: got %b want 0", pix_valid); else pass_cnt++;
    chk_cnt++; if (h_total !== 10'd0) $display("FAIL reset_h_total: got %0d want 0", h_total); else pass_cnt++;
    chk_cnt++; if (v_total !== 10'd0) $display("FAIL reset_v_total: got %0d want 0", v_total); else pass_cnt++;
    chk_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else pass_cnt++;
    chk_cnt++; if (sync_err !== 1'b0) $display("FAIL reset_sync_err: got %b want 0", sync_err); else pass_cnt++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_lock();
    int b;
    b = v_edges;
    repeat (3) send_lines(0, 11, -1, -1);
    chk_cnt++; if (snap_locked[b+1] !== 1'b0) $display("FAIL lock_edge1: got %b want 0", snap_locked[b+1]); else pass_cnt++;
    chk_cnt++; if (snap_htot[b+2] !== 10'd24) $display("FAIL lock_h_total: got %0d want 24", snap_htot[b+2]); else pass_cnt++;
    chk_cnt++; if (snap_vtot[b+2] !== 10'd12) $display("FAIL lock_v_total: got %0d want 12", snap_vtot[b+2]); else pass_cnt++;
    chk_cnt++; if (snap_locked[b+2] !== 1'b0) $display("FAIL lock_edge2: got %b want 0", snap_locked[b+2]); else pass_cnt++;
    chk_cnt++; if (snap_pre[b+3] !== 1'b0) $display("FAIL lock_before_edge3: got %b want 0", snap_pre[b+3]); else pass_cnt++;
    chk_cnt++; if (snap_locked[b+3] !== 1'b1) $display("FAIL lock_edge3: got %b want 1", snap_locked[b+3]); else pass_cnt++;
  endtask

  task automatic test_frame_pixels();
    int e0;
    e0 = err_seen;
    pv_seen = 0;
    send_lines(0, 11, -1, -1);
    chk_cnt++; if (pv_seen != H_ACT * V_ACT) $display("FAIL frame_pixel_count: got %0d want %0d", pv_seen, H_ACT * V_ACT); else pass_cnt++;
    chk_cnt++; if (first_xy !== 20'd0) $display("FAIL frame_first_pixel: got y=%0d x=%0d want 0/0", first_xy[19:10], first_xy[9:0]); else pass_cnt++;
    chk_cnt++; if (last_xy !== {10'(V_ACT - 1), 10'(H_ACT - 1)}) $display("FAIL frame_last_pixel: got y=%0d x=%0d want y=%0d x=%0d", last_xy[19:10], last_xy[9:0], V_ACT - 1, H_ACT - 1); else pass_cnt++;
    chk_cnt++; if (err_seen != e0) $display("FAIL frame_no_err: got %0d pulses want 0", err_seen - e0); else pass_cnt++;
  endtask

  task automatic test_long_line();
    int b, e0;
    b = v_edges; e0 = err_seen;
    send_lines(0, 11, 3, -1);
    chk_cnt++; if (err_seen - e0 != 1) $display("FAIL long_err_pulses: got %0d want 1", err_seen - e0); else pass_cnt++;
    chk_cnt++; if (locked !== 1'b0) $display("FAIL long_unlocked: got %b want 0", locked); else pass_cnt++;
    send_lines(0, 11, -1, -1);
    send_lines(0, 11, -1, -1);
    chk_cnt++; if (snap_locked[b+2] !== 1'b0) $display("FAIL long_relock_edge2: got %b want 0", snap_locked[b+2]); else pass_cnt++;
    chk_cnt++; if (snap_locked[b+3] !== 1'b1) $display("FAIL long_relock_edge3: got %b want 1", snap_locked[b+3]); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int b, e0, hit;
    send_lines(0, 11, -1, -1);
    e0 = err_seen; hit = -1;
    exp_lock = 0; lock_cd = 3; exp_err++;
    // Last h_sync fall left 5 samples counted; the counter reaches 1023 on hold sample 1017.
    for (int k = 0; k < 1100; k++) begin
      drive_sample(1'b1, 1'b1, 1'b0, 0, 0);
      if (last_err === 1'b1 && hit < 0) hit = k;
    end
    chk_cnt++; if (hit != 1017) $display("FAIL sat_err_sample: got %0d want 1017", hit); else pass_cnt++;
    chk_cnt++; if (err_seen - e0 != 1) $display("FAIL sat_err_pulses: got %0d want 1", err_seen - e0); else pass_cnt++;
    chk_cnt++; if (locked !== 1'b0) $display("FAIL sat_unlocked: got %b want 0", locked); else pass_cnt++;
    b = v_edges;
    repeat (3) send_lines(0, 11, -1, -1);
    chk_cnt++; if (snap_locked[b+3] !== 1'b1) $display("FAIL sat_relock: got %b want 1", snap_locked[b+3]); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int b, e0;
    send_lines(0, 1, -1, -1);
    e0 = err_seen;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if ({x_pixel, y_pixel, h_total, v_total} !== 40'd0) $display("FAIL midrst_values: got x=%0d y=%0d ht=%0d vt=%0d want all 0", x_pixel, y_pixel, h_total, v_total); else pass_cnt++;
    chk_cnt++; if ({pix_valid, locked, sync_err} !== 3'b000) $display("FAIL midrst_flags: got %b want 000", {pix_valid, locked, sync_err}); else pass_cnt++;
    reset = 1'b0;
    model_reset();
    b = v_edges;
    send_lines(2, 11, -1, -1);
    send_lines(0, 11, -1, -1);
    send_lines(0, 11, -1, -1);
    chk_cnt++; if (err_seen != e0) $display("FAIL midrst_no_err: got %0d pulses want 0", err_seen - e0); else pass_cnt++;
    chk_cnt++; if (snap_locked[b+2] !== 1'b0) $display("FAIL midrst_edge2: got %b want 0", snap_locked[b+2]); else pass_cnt++;
    chk_cnt++; if (snap_locked[b+3] !== 1'b1) $display("FAIL midrst_edge3: got %b want 1", snap_locked[b+3]); else pass_cnt++;
  endtask

  task automatic test_verify_relatch();
    int b;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    lock_cd = 4;
    b = v_edges;
    send_lines(0, 11, -1, -1);
    send_lines(0, 12, -1, -1);
    send_lines(0, 12, -1, -1);
    send_lines(0, 11, -1, -1);
    chk_cnt++; if (snap_vtot[b+2] !== 10'd12) $display("FAIL verify_vt_first: got %0d want 12", snap_vtot[b+2]); else pass_cnt++;
    chk_cnt++; if (snap_locked[b+3] !== 1'b0) $display("FAIL verify_no_lock: got %b want 0", snap_locked[b+3]); else pass_cnt++;
    chk_cnt++; if (snap_vtot[b+3] !== 10'd13) $display("FAIL verify_vt_relatch: got %0d want 13", snap_vtot[b+3]); else pass_cnt++;
    chk_cnt++; if (snap_locked[b+4] !== 1'b1) $display("FAIL verify_lock: got %b want 1", snap_locked[b+4]); else pass_cnt++;
  endtask

  task automatic test_de_short();
    int e0;
    e0 = err_seen;
    send_lines(0, 11, -1, 2);
    chk_cnt++; if (err_seen - e0 != 1) $display("FAIL de_short_err: got %0d pulses want 1", err_seen - e0); else pass_cnt++;
    chk_cnt++; if (locked !== 1'b0) $display("FAIL de_short_unlocked: got %b want 0", locked); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_frame_pixels();
    test_long_line();
    test_saturation();
    test_reset_midframe();
    test_verify_relatch();
    test_de_short();
    repeat (4) @(posedge clk);
    #1;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else pass_cnt++;
    chk_cnt++; if (err_seen != exp_err) $display("FAIL total_err_pulses: got %0d want %0d", err_seen, exp_err); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 The parameter H_ACTIVE SHALL default to 640 and give the expected DE-high pixels per line.
REQ-002 The parameter V_ACTIVE SHALL default to 480 and give the expected DE-active lines per frame.
REQ-003 The port clk SHALL be a 1-bit input and the single system clock; all logic is on its rising edge.
REQ-004 The port reset SHALL be a 1-bit input, synchronous and active-high.
REQ-005 The port pix_en SHALL be a 1-bit input, a one-clk pixel strobe; all video inputs are sampled only on cycles with pix_en=1.
REQ-006 The port h_sync SHALL be a 1-bit input, active-low horizontal sync.
REQ-007 The port v_sync SHALL be a 1-bit input, active-low vertical sync.
REQ-008 The port DE SHALL be a 1-bit input, data-enable (visible pixel).
REQ-009 The port x_pixel SHALL be a 10-bit output, the recovered column of the current pixel.
REQ-010 The port y_pixel SHALL be a 10-bit output, the recovered row of the current pixel.
REQ-011 The port pix_valid SHALL be a 1-bit output, high for one clk per visible pixel while locked.
REQ-012 The port h_total SHALL be a 10-bit output, the measured line period in pix_en samples.
REQ-013 The port v_total SHALL be a 10-bit output, the measured frame period in lines.
REQ-014 The port locked SHALL be a 1-bit output, high when the timing is stable.
REQ-015 The port sync_err SHALL be a 1-bit output, a one-clk pulse on loss of lock.

Function
REQ-016 Edge detection SHALL compare the current pix_en sample with the previous one; a falling edge is previous=1 and current=0.
REQ-017 The period counter SHALL count pix_en samples and saturate at 1023; on each h_sync falling edge its value +1 is captured as the line period and the counter clears to 0.
REQ-018 The line counter SHALL increment on each h_sync falling edge and saturate at 1023; on a v_sync falling edge its post-increment value is captured as the frame period and it clears to 0.
REQ-019 An h_sync edge and a v_sync edge in the same sample SHALL both be processed in that sample, with the line increment applied before capture.
REQ-020 The FSM SHALL have the states SEARCH, MEASURE, VERIFY and LOCKED; it resets to SEARCH.
REQ-021 From SEARCH, the FSM SHALL go to MEASURE on the first v_sync falling edge.
REQ-022 From MEASURE, on the next v_sync falling edge the FSM SHALL latch h_total (last line period) and v_total (frame period), then go to VERIFY.
REQ-023 In VERIFY, any line period that differs from h_total SHALL send the FSM back to MEASURE.
REQ-024 In VERIFY, at a v_sync edge with frame period equal to v_total the FSM SHALL go to LOCKED; otherwise it SHALL relatch both totals and stay in VERIFY.
REQ-025 In LOCKED, the FSM SHALL go to SEARCH and pulse sync_err for one clk on any of:
- line period differs from h_total;
- frame period differs from v_total;
- either counter saturates;
- DE-high count of a completed line (at DE falling edge) differs from H_ACTIVE.
REQ-026 locked SHALL be high exactly while the state is LOCKED, registered, and assert one clk after the qualifying pix_en sample.
REQ-027 x_pixel SHALL clear to 0 on a DE rising edge and increment on each subsequent sample with DE=1.
REQ-028 y_pixel SHALL clear to 0 on the first DE rising edge after a v_sync falling edge and increment on each later DE rising edge.
REQ-029 x_pixel and y_pixel SHALL saturate at 1023.
REQ-030 pix_valid SHALL pulse one clk after each pix_en sample with DE=1 while locked, with x_pixel/y_pixel of that pixel valid in the same clk (latency 1 clk).
REQ-031 h_total and v_total SHALL hold their last latched values until relatched.

Reset
REQ-032 On reset=1 at a clk edge, all outputs SHALL go to 0, all counters to 0, the state to SEARCH, and the previous-sample registers for h_sync/v_sync to 1 and for DE to 0, so the first samples produce no spurious edges.
REQ-033 A reset asserted mid-frame SHALL discard all measurements; lock requires a new SEARCH->MEASURE->VERIFY->LOCKED sequence.

Verification
REQ-034 Standard 640x480 timing, pix_en 1-in-4: 800 samples/line, h_sync low at 656..751, v_sync low on lines 490..491, 525 lines -> h_total=800 and v_total=525 after the 2nd v_sync edge; locked=1 one clk after the 3rd v_sync edge sample.
REQ-035 Locked stream with first pixel of line 0 -> pix_valid with x_pixel=0, y_pixel=0; last visible pixel -> x_pixel=639, y_pixel=479; 307200 pix_valid pulses per frame.
REQ-036 Locked stream, one line lengthened to 801 samples -> sync_err one clk, locked=0, state SEARCH; relocks after 3 further v_sync edges.
REQ-037 h_sync held high while locked -> period counter saturates at 1023 -> sync_err pulse, locked=0.
REQ-038 In VERIFY, a frame of 526 lines -> no lock, v_total=526; the next 526-line frame -> locked=1.
REQ-039 reset pulsed for one clk mid-frame while locked -> all outputs 0 the next clk, no sync_err; locks again on the 3rd subsequent v_sync edge.
